// File: rtl/memory_access_if.sv
// Data-memory bus between the memory-access stage (master) and the data
// memory (slave). One request is outstanding at a time; mem_ack is a
// single-cycle completion pulse.
interface memory_access_if;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_rdata;
  logic        mem_ack;

  modport master (
    output mem_req,
    output mem_we,
    output mem_addr,
    output mem_wdata,
    output mem_wstrb,
    input  mem_rdata,
    input  mem_ack
  );

  modport slave (
    input  mem_req,
    input  mem_we,
    input  mem_addr,
    input  mem_wdata,
    input  mem_wstrb,
    output mem_rdata,
    output mem_ack
  );
endinterface

// File: rtl/memory_access.sv
// Memory-access pipeline stage. Non-memory results pass to writeback with
// one cycle of latency; loads and stores issue a single word-aligned request
// on the data bus and stall upstream until mem_ack.
// Optional feature macro: MISALIGN_TRAP_EN (misaligned half/word accesses
// are not issued and instead complete with misalign_err for one cycle).
module memory_access (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_in,
  input  logic [31:0] alu_result,
  input  logic [31:0] rs2E,
  input  logic        write_regE,
  input  logic [2:0]  info_loadE,
  input  logic [1:0]  info_storeE,
  input  logic [4:0]  dstreg_addrE,
  output logic        stall,
  memory_access_if.master mem_bus,
  output logic        valid_out,
  output logic        write_regM,
  output logic [4:0]  dstreg_addrM,
  output logic [31:0] wb_data
`ifdef MISALIGN_TRAP_EN
  ,
  output logic        misalign_err
`endif
);

  typedef enum logic {
    S_IDLE,
    S_REQ
  } state_t;

  typedef enum logic [2:0] {
    LK_NONE,
    LK_B,
    LK_H,
    LK_W,
    LK_BU,
    LK_HU
  } ld_kind_t;

  typedef enum logic [1:0] {
    SK_NONE,
    SK_B,
    SK_H,
    SK_W
  } st_kind_t;

  state_t   state;
  ld_kind_t ld_kind;
  st_kind_t st_kind;
  logic     is_store;
  logic     is_load;
  logic [31:0] st_wdata;
  logic [3:0]  st_wstrb;

  // Captured at request issue; used when the ack returns.
  ld_kind_t    ld_q;
  logic [1:0]  off_q;
  logic        store_q;
  logic        wr_q;
  logic [4:0]  dst_q;

  logic [7:0]  rd_byte;
  logic [15:0] rd_half;
  logic [31:0] load_data;

  // Decode the execute-stage operation; a store wins over a load.
  always_comb begin
    ld_kind = LK_NONE;
    case (info_loadE)
      3'd1:    ld_kind = LK_B;
      3'd2:    ld_kind = LK_H;
      3'd3:    ld_kind = LK_W;
      3'd4:    ld_kind = LK_BU;
      3'd5:    ld_kind = LK_HU;
      default: ld_kind = LK_NONE;
    endcase
    st_kind = st_kind_t'(info_storeE);
    is_store = (st_kind != SK_NONE);
    is_load  = !is_store && (ld_kind != LK_NONE);
  end

  // Store lane replication and byte strobes from the low address bits.
  always_comb begin
    st_wdata = rs2E;
    st_wstrb = '0;
    case (st_kind)
      SK_B: begin
        st_wdata = {4{rs2E[7:0]}};
        st_wstrb = 4'b0001 << alu_result[1:0];
      end
      SK_H: begin
        st_wdata = {2{rs2E[15:0]}};
        st_wstrb = alu_result[1] ? 4'b1100 : 4'b0011;
      end
      SK_W: begin
        st_wdata = rs2E;
        st_wstrb = 4'b1111;
      end
      default: begin
        st_wdata = rs2E;
        st_wstrb = '0;
      end
    endcase
  end

`ifdef MISALIGN_TRAP_EN
  logic misaligned;

  // Half accesses need addr[0]=0, word accesses need addr[1:0]=00.
  always_comb begin
    misaligned = 1'b0;
    if (is_store) begin
      if (st_kind == SK_H)
        misaligned = alu_result[0];
      else if (st_kind == SK_W)
        misaligned = (alu_result[1:0] != 2'b00);
    end else if (ld_kind == LK_H || ld_kind == LK_HU) begin
      misaligned = alu_result[0];
    end else if (ld_kind == LK_W) begin
      misaligned = (alu_result[1:0] != 2'b00);
    end
  end
`endif

  // Extract and extend the loaded value from the returned word.
  always_comb begin
    rd_byte   = mem_bus.mem_rdata[{off_q, 3'b000} +: 8];
    rd_half   = off_q[1] ? mem_bus.mem_rdata[31:16] : mem_bus.mem_rdata[15:0];
    load_data = mem_bus.mem_rdata;
    case (ld_q)
      LK_B:    load_data = {{24{rd_byte[7]}}, rd_byte};
      LK_BU:   load_data = {24'd0, rd_byte};
      LK_H:    load_data = {{16{rd_half[15]}}, rd_half};
      LK_HU:   load_data = {16'd0, rd_half};
      default: load_data = mem_bus.mem_rdata;
    endcase
  end

  // Stage FSM: accept in IDLE, hold the request in REQ until mem_ack.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state             <= S_IDLE;
      stall             <= 1'b0;
      mem_bus.mem_req   <= 1'b0;
      mem_bus.mem_we    <= 1'b0;
      mem_bus.mem_addr  <= '0;
      mem_bus.mem_wdata <= '0;
      mem_bus.mem_wstrb <= '0;
      valid_out         <= 1'b0;
      write_regM        <= 1'b0;
      dstreg_addrM      <= '0;
      wb_data           <= '0;
      ld_q              <= LK_NONE;
      off_q             <= '0;
      store_q           <= 1'b0;
      wr_q              <= 1'b0;
      dst_q             <= '0;
`ifdef MISALIGN_TRAP_EN
      misalign_err      <= 1'b0;
`endif
    end else begin
      valid_out  <= 1'b0;
      write_regM <= 1'b0;
`ifdef MISALIGN_TRAP_EN
      misalign_err <= 1'b0;
`endif
      case (state)
        S_IDLE: begin
          if (valid_in) begin
            if (is_store || is_load) begin
`ifdef MISALIGN_TRAP_EN
              // A trapped access completes at once and never reaches the bus.
              if (misaligned) begin
                valid_out    <= 1'b1;
                misalign_err <= 1'b1;
                dstreg_addrM <= dstreg_addrE;
              end else
`endif
              begin
                state             <= S_REQ;
                stall             <= 1'b1;
                mem_bus.mem_req   <= 1'b1;
                mem_bus.mem_we    <= is_store;
                mem_bus.mem_addr  <= {alu_result[31:2], 2'b00};
                mem_bus.mem_wdata <= is_store ? st_wdata : '0;
                mem_bus.mem_wstrb <= is_store ? st_wstrb : '0;
                ld_q              <= is_store ? LK_NONE : ld_kind;
                off_q             <= alu_result[1:0];
                store_q           <= is_store;
                wr_q              <= write_regE;
                dst_q             <= dstreg_addrE;
              end
            end else begin
              valid_out    <= 1'b1;
              write_regM   <= write_regE;
              dstreg_addrM <= dstreg_addrE;
              wb_data      <= alu_result;
            end
          end
        end
        S_REQ: begin
          if (mem_bus.mem_ack) begin
            state             <= S_IDLE;
            stall             <= 1'b0;
            mem_bus.mem_req   <= 1'b0;
            mem_bus.mem_we    <= 1'b0;
            mem_bus.mem_wstrb <= '0;
            valid_out         <= 1'b1;
            write_regM        <= wr_q && !store_q;
            dstreg_addrM      <= dst_q;
            wb_data           <= store_q ? '0 : load_data;
          end
        end
        default: begin
          state           <= S_IDLE;
          stall           <= 1'b0;
          mem_bus.mem_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_memory_access.sv
// Bench for memory_access: directed cases with literal expectations, then
// randomized instruction/ack traffic checked each cycle against a
// transaction-level model.
module tb_memory_access;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_in;
  logic [31:0] alu_result;
  logic [31:0] rs2E;
  logic        write_regE;
  logic [2:0]  info_loadE;
  logic [1:0]  info_storeE;
  logic [4:0]  dstreg_addrE;
  logic        stall;
  logic        valid_out;
  logic        write_regM;
  logic [4:0]  dstreg_addrM;
  logic [31:0] wb_data;
`ifdef MISALIGN_TRAP_EN
  logic        misalign_err;
`endif

  memory_access_if bus();

  memory_access dut (
    .clk          (clk),
    .rst          (rst),
    .valid_in     (valid_in),
    .alu_result   (alu_result),
    .rs2E         (rs2E),
    .write_regE   (write_regE),
    .info_loadE   (info_loadE),
    .info_storeE  (info_storeE),
    .dstreg_addrE (dstreg_addrE),
    .stall        (stall),
    .mem_bus      (bus),
    .valid_out    (valid_out),
    .write_regM   (write_regM),
    .dstreg_addrM (dstreg_addrM),
    .wb_data      (wb_data)
`ifdef MISALIGN_TRAP_EN
    ,
    .misalign_err (misalign_err)
`endif
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endfunction

  // ---------------- reference rules ----------------
  function automatic logic [31:0] ref_wdata(logic [1:0] st, logic [31:0] v);
    if (st == 2'd1) return (v & 32'hFF) * 32'h01010101;
    if (st == 2'd2) return (v & 32'hFFFF) * 32'h00010001;
    return v;
  endfunction

  function automatic logic [3:0] ref_wstrb(logic [1:0] st, logic [31:0] a);
    int unsigned off;
    off = a % 4;
    if (st == 2'd1) return 4'(1 << off);
    if (st == 2'd2) return 4'(3 << (off & 2));
    return 4'hF;
  endfunction

  function automatic logic [31:0] ref_load(logic [2:0] ld, logic [31:0] a, logic [31:0] rd);
    logic [31:0] v;
    int unsigned off;
    off = a % 4;
    if (ld == 3'd1 || ld == 3'd4) begin
      v = (rd >> (8 * off)) & 32'hFF;
      if (ld == 3'd1 && v >= 32'h80) v = v - 32'h100;
    end else if (ld == 3'd2 || ld == 3'd5) begin
      v = (rd >> (16 * (off / 2))) & 32'hFFFF;
      if (ld == 3'd2 && v >= 32'h8000) v = v - 32'h10000;
    end else begin
      v = rd;
    end
    return v;
  endfunction

`ifdef MISALIGN_TRAP_EN
  function automatic logic ref_misaligned(logic [2:0] ld, logic [1:0] st, logic [31:0] a);
    int unsigned size;
    if (st != 2'd0) size = 1 << (st - 1);
    else if (ld == 3'd2 || ld == 3'd5) size = 2;
    else if (ld == 3'd3) size = 4;
    else size = 1;
    return (a % size) != 0;
  endfunction
`endif

  // ---------------- transaction model ----------------
  logic        pend = 1'b0;
  logic [2:0]  p_ld;
  logic [1:0]  p_st;
  logic [31:0] p_a, p_rs2;
  logic        p_wr;
  logic [4:0]  p_dst;
  logic        e_v = 1'b0, e_wr = 1'b0, e_chk_wb = 1'b0, e_err = 1'b0;
  logic [4:0]  e_dst = '0;
  logic [31:0] e_wb = '0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      pend = 1'b0;
      e_v = 1'b0;
      e_wr = 1'b0;
      e_err = 1'b0;
    end else begin
      e_v = 1'b0;
      e_wr = 1'b0;
      e_err = 1'b0;
      if (pend) begin
        if (bus.mem_ack) begin
          pend = 1'b0;
          e_v = 1'b1;
          e_dst = p_dst;
          if (p_st != 2'd0) begin
            e_chk_wb = 1'b0;
          end else begin
            e_wr = p_wr;
            e_chk_wb = 1'b1;
            e_wb = ref_load(p_ld, p_a, bus.mem_rdata);
          end
        end
      end else if (valid_in) begin
        if (info_storeE == 2'd0 && (info_loadE == 3'd0 || info_loadE > 3'd5)) begin
          e_v = 1'b1;
          e_wr = write_regE;
          e_dst = dstreg_addrE;
          e_wb = alu_result;
          e_chk_wb = 1'b1;
        end
`ifdef MISALIGN_TRAP_EN
        else if (ref_misaligned(info_loadE, info_storeE, alu_result)) begin
          e_v = 1'b1;
          e_err = 1'b1;
          e_chk_wb = 1'b0;
        end
`endif
        else begin
          pend = 1'b1;
          p_ld = info_loadE;
          p_st = info_storeE;
          p_a = alu_result;
          p_rs2 = rs2E;
          p_wr = write_regE;
          p_dst = dstreg_addrE;
        end
      end
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    chk("valid_out", valid_out, e_v);
    chk("write_regM", write_regM, e_v ? e_wr : 1'b0);
    if (e_v && e_wr) chk("dstreg_addrM", dstreg_addrM, e_dst);
    if (e_v && e_chk_wb) chk("wb_data", wb_data, e_wb);
    chk("stall", stall, pend);
    chk("mem_req", bus.mem_req, pend);
    if (pend) begin
      chk("mem_we", bus.mem_we, p_st != 2'd0);
      chk("mem_addr", bus.mem_addr, p_a & 32'hFFFF_FFFC);
      if (p_st != 2'd0) begin
        chk("mem_wdata", bus.mem_wdata, ref_wdata(p_st, p_rs2));
        chk("mem_wstrb", bus.mem_wstrb, ref_wstrb(p_st, p_a));
      end
    end
`ifdef MISALIGN_TRAP_EN
    chk("misalign_err", misalign_err, e_err);
`endif
  end

  // ---------------- memory responder ----------------
  int          ack_delay = 3;  // 0 selects a random delay per request
  int          cnt = 0, cur_delay = 1;
  logic        resp_en = 1'b1, force_ack = 1'b0, spur_en = 1'b0, rd_rand = 1'b0;
  logic [31:0] rd_fixed = 32'h80FF_FFFF;

  initial begin
    bus.mem_ack = 1'b0;
    bus.mem_rdata = '0;
    forever begin
      @(posedge clk);
      #1;
      if (!resp_en) begin
        cnt = 0;
        bus.mem_ack = force_ack;
        bus.mem_rdata = $urandom;
      end else if (bus.mem_req) begin
        if (cnt == 0) cur_delay = (ack_delay == 0) ? int'($urandom_range(1, 4)) : ack_delay;
        cnt++;
        if (cnt >= cur_delay) begin
          bus.mem_ack = 1'b1;
          bus.mem_rdata = rd_rand ? $urandom : rd_fixed;
          cnt = 0;
        end else begin
          bus.mem_ack = 1'b0;
          bus.mem_rdata = $urandom;
        end
      end else begin
        cnt = 0;
        bus.mem_ack = spur_en && ($urandom_range(0, 3) == 0);
        bus.mem_rdata = $urandom;
      end
    end
  end

  // ---------------- directed helper ----------------
  typedef struct {
    int          lat;
    int          stalls;
    logic [31:0] wb;
    logic        wrm;
    logic [4:0]  dm;
    logic        saw_req;
    logic [31:0] maddr;
    logic [31:0] mwdata;
    logic [3:0]  mstrb;
    logic        mwe;
`ifdef MISALIGN_TRAP_EN
    logic        err;
`endif
  } res_t;

  task automatic run_op(input logic [2:0] ld, input logic [1:0] st, input logic [31:0] a,
                        input logic [31:0] d, input logic wr, input logic [4:0] dst,
                        output res_t r);
    r = '{default: '0};
    @(posedge clk);
    #1;
    valid_in = 1'b1;
    info_loadE = ld;
    info_storeE = st;
    alu_result = a;
    rs2E = d;
    write_regE = wr;
    dstreg_addrE = dst;
    @(posedge clk);
    #1;
    valid_in = 1'b0;
    for (int c = 1; c <= 50; c++) begin
      @(negedge clk);
      if (stall) r.stalls++;
      if (bus.mem_req) begin
        r.saw_req = 1'b1;
        r.maddr = bus.mem_addr;
        r.mwdata = bus.mem_wdata;
        r.mstrb = bus.mem_wstrb;
        r.mwe = bus.mem_we;
      end
`ifdef MISALIGN_TRAP_EN
      if (misalign_err) r.err = 1'b1;
`endif
      if (valid_out) begin
        r.lat = c;
        r.wb = wb_data;
        r.wrm = write_regM;
        r.dm = dstreg_addrM;
        break;
      end
    end
    if (r.lat == 0) chk("op_timeout", r.lat, 1);
  endtask

  res_t r;

  initial begin
    rst = 1'b1;
    valid_in = 1'b0;
    alu_result = '0;
    rs2E = '0;
    write_regE = 1'b0;
    info_loadE = '0;
    info_storeE = '0;
    dstreg_addrE = '0;
    repeat (2) @(negedge clk);
    chk("rst_stall", stall, 0);
    chk("rst_mem_req", bus.mem_req, 0);
    chk("rst_mem_we", bus.mem_we, 0);
    chk("rst_mem_addr", bus.mem_addr, 0);
    chk("rst_mem_wdata", bus.mem_wdata, 0);
    chk("rst_mem_wstrb", bus.mem_wstrb, 0);
    chk("rst_valid_out", valid_out, 0);
    chk("rst_write_regM", write_regM, 0);
    chk("rst_dstreg_addrM", dstreg_addrM, 0);
    chk("rst_wb_data", wb_data, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // non-memory pass-through
    run_op(3'd0, 2'd0, 32'h1234, 32'h0, 1'b1, 5'd5, r);
    chk("alu_lat", r.lat, 1);
    chk("alu_wb", r.wb, 32'h1234);
    chk("alu_dst", r.dm, 5);
    chk("alu_wrm", r.wrm, 1);
    chk("alu_stalls", r.stalls, 0);

    // LB / LBU at 0x103, ack after 3 REQ cycles
    run_op(3'd1, 2'd0, 32'h103, 32'h0, 1'b1, 5'd7, r);
    chk("lb_addr", r.maddr, 32'h100);
    chk("lb_stalls", r.stalls, 3);
    chk("lb_wb", r.wb, 32'hFFFF_FF80);
    chk("lb_wrm", r.wrm, 1);
    chk("lb_we", r.mwe, 0);
    run_op(3'd4, 2'd0, 32'h103, 32'h0, 1'b1, 5'd7, r);
    chk("lbu_wb", r.wb, 32'h0000_0080);

    // SH at 0x202
    run_op(3'd0, 2'd2, 32'h202, 32'hAABB_CCDD, 1'b1, 5'd9, r);
    chk("sh_we", r.mwe, 1);
    chk("sh_wdata", r.mwdata, 32'hCCDD_CCDD);
    chk("sh_wstrb", r.mstrb, 4'b1100);
    chk("sh_wrm", r.wrm, 0);

    // load and store together behave as a store
    run_op(3'd3, 2'd1, 32'h301, 32'h0000_005A, 1'b1, 5'd3, r);
    chk("ldst_we", r.mwe, 1);
    chk("ldst_wstrb", r.mstrb, 4'b0010);
    chk("ldst_wdata", r.mwdata, 32'h5A5A_5A5A);
    chk("ldst_wrm", r.wrm, 0);

    // LW at 0x6
    rd_fixed = 32'h1122_3344;
    run_op(3'd3, 2'd0, 32'h6, 32'h0, 1'b1, 5'd4, r);
`ifdef MISALIGN_TRAP_EN
    chk("lw6_req", r.saw_req, 0);
    chk("lw6_err", r.err, 1);
    chk("lw6_wrm", r.wrm, 0);
    chk("lw6_lat", r.lat, 1);
`else
    chk("lw6_req", r.saw_req, 1);
    chk("lw6_addr", r.maddr, 32'h4);
    chk("lw6_wb", r.wb, 32'h1122_3344);
`endif

    // reset in the middle of a request, then stray acks
    resp_en = 1'b0;
    @(posedge clk);
    #1;
    valid_in = 1'b1;
    info_loadE = 3'd3;
    info_storeE = 2'd0;
    alu_result = 32'h40;
    write_regE = 1'b1;
    @(posedge clk);
    #1;
    valid_in = 1'b0;
    @(negedge clk);
    chk("mid_req_before_rst", bus.mem_req, 1);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_req", bus.mem_req, 0);
    chk("mid_rst_stall", stall, 0);
    @(negedge clk);
    rst = 1'b0;
    force_ack = 1'b1;
    @(negedge clk);
    force_ack = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("post_rst_valid", valid_out, 0);
      chk("post_rst_stall", stall, 0);
    end
    resp_en = 1'b1;

    // randomized traffic
    ack_delay = 0;
    rd_rand = 1'b1;
    spur_en = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      logic held;
      @(negedge clk);
      held = stall;
      @(posedge clk);
      #1;
      if (!held) begin
        valid_in = ($urandom_range(0, 3) != 0);
        info_storeE = ($urandom_range(0, 2) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
        info_loadE = 3'($urandom_range(0, 7));
        alu_result = $urandom;
        rs2E = $urandom;
        write_regE = 1'($urandom_range(0, 1));
        dstreg_addrE = 5'($urandom);
      end
    end
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
